pipeline_pack_reduce: RTL and testbench

- Parametrised output-combining stage for a pack of NUM_LANES permutation pipelines sharing one top/bot stream.
- Reduces per-lane partial sums, pcoeff counts and FIFO fullness through a registered adder/max tree.
- Tags each result with its botIndex.
- Keeps a running saturating total per top, with a clear strobe, ahead of the result collector.

---
 rtl/pipeline_pack_reduce.sv | 148 ++++++++++++++
 tb/tb_pipeline_pack_reduce.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_pack_reduce.sv
// Output-combining stage for a pack of lane pipelines: registered adder/max trees,
// botIndex tagging and a saturating running total per top.
module pipeline_pack_reduce #(
  parameter int NUM_LANES             = 4,
  parameter int SUM_WIDTH             = 38,
  parameter int COUNT_WIDTH           = 3,
  parameter int FULLNESS_WIDTH        = 5,
  parameter int ADDR_WIDTH            = 9,
  parameter int TOTAL_WIDTH           = 48,
  parameter int ALMOST_FULL_THRESHOLD = 20,
  localparam int L = (NUM_LANES <= 1) ? 1 : $clog2(NUM_LANES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_LANES*SUM_WIDTH-1:0]      laneSums,
  input  logic [NUM_LANES*COUNT_WIDTH-1:0]    laneCounts,
  input  logic [NUM_LANES*FULLNESS_WIDTH-1:0] laneFullness,
  input  logic                                inValid,
  input  logic [ADDR_WIDTH-1:0]               inBotIndex,
  input  logic                                clearTotal,
  output logic                                outValid,
  output logic [ADDR_WIDTH-1:0]               outBotIndex,
  output logic [SUM_WIDTH+L-1:0]              summedData,
  output logic [COUNT_WIDTH+L-1:0]            pcoeffCount,
  output logic [FULLNESS_WIDTH-1:0]           maxFullness,
  output logic                                almostFull,
  output logic [TOTAL_WIDTH-1:0]              totalSum,
  output logic                                totalOverflow
);

  localparam int P  = 1 << L;
  localparam int SW = SUM_WIDTH + L;
  localparam int CW = COUNT_WIDTH + L;
  localparam int AW = ((TOTAL_WIDTH > SW) ? TOTAL_WIDTH : SW) + 1;
  localparam logic [TOTAL_WIDTH-1:0]    TOTAL_MAX = '1;
  localparam logic [FULLNESS_WIDTH-1:0] AF_TH     = FULLNESS_WIDTH'(ALMOST_FULL_THRESHOLD);

  function automatic logic [FULLNESS_WIDTH-1:0] max_f(input logic [FULLNESS_WIDTH-1:0] a,
                                                       input logic [FULLNESS_WIDTH-1:0] b);
    max_f = (a >= b) ? a : b;
  endfunction

  // Returns {overflow, value}; value clamps to all ones when the true sum does not fit.
  function automatic logic [TOTAL_WIDTH:0] sat_add(input logic [TOTAL_WIDTH-1:0] a,
                                                   input logic [SW-1:0] b);
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    if (s > AW'(TOTAL_MAX)) sat_add = {1'b1, TOTAL_MAX};
    else                    sat_add = {1'b0, s[TOTAL_WIDTH-1:0]};
  endfunction

  logic [SW-1:0]             lane_sum  [P];
  logic [CW-1:0]             lane_cnt  [P];
  logic [FULLNESS_WIDTH-1:0] lane_full [P];

  for (genvar j = 0; j < P; j++) begin : g_pad
    if (j < NUM_LANES) begin : g_live
      assign lane_sum[j]  = SW'(laneSums[j*SUM_WIDTH +: SUM_WIDTH]);
      assign lane_cnt[j]  = CW'(laneCounts[j*COUNT_WIDTH +: COUNT_WIDTH]);
      assign lane_full[j] = laneFullness[j*FULLNESS_WIDTH +: FULLNESS_WIDTH];
    end else begin : g_zero
      assign lane_sum[j]  = '0;
      assign lane_cnt[j]  = '0;
      assign lane_full[j] = '0;
    end
  end

  logic [SW-1:0]             sum_p  [1:L][P/2];
  logic [CW-1:0]             cnt_p  [1:L][P/2];
  logic [FULLNESS_WIDTH-1:0] full_p [1:L][P/2];
  logic [ADDR_WIDTH-1:0]     idx_p  [1:L];
  logic [L:1]                vld_p;
  logic [L:0]                en_all;

  // en_all[k] is the valid bit entering tree level k+1; en_all[L] is the output valid.
  assign en_all = {vld_p, inValid};

  // Tree levels p1..pL: data only advances with its valid so the output holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      for (int k = 1; k <= L; k++) begin
        idx_p[k] <= '0;
        for (int j = 0; j < P/2; j++) begin
          sum_p[k][j]  <= '0;
          cnt_p[k][j]  <= '0;
          full_p[k][j] <= '0;
        end
      end
    end else begin
      vld_p <= en_all[L-1:0];
      for (int j = 0; j < P/2; j++)
        full_p[1][j] <= max_f(lane_full[2*j], lane_full[2*j+1]);
      if (inValid) begin
        idx_p[1] <= inBotIndex;
        for (int j = 0; j < P/2; j++) begin
          sum_p[1][j] <= lane_sum[2*j] + lane_sum[2*j+1];
          cnt_p[1][j] <= lane_cnt[2*j] + lane_cnt[2*j+1];
        end
      end
      for (int k = 2; k <= L; k++) begin
        for (int j = 0; j < (P >> k); j++)
          full_p[k][j] <= max_f(full_p[k-1][2*j], full_p[k-1][2*j+1]);
        if (vld_p[k-1]) begin
          idx_p[k] <= idx_p[k-1];
          for (int j = 0; j < (P >> k); j++) begin
            sum_p[k][j] <= sum_p[k-1][2*j] + sum_p[k-1][2*j+1];
            cnt_p[k][j] <= cnt_p[k-1][2*j] + cnt_p[k-1][2*j+1];
          end
        end
      end
    end
  end

  assign outValid    = en_all[L];
  assign outBotIndex = idx_p[L];
  assign summedData  = sum_p[L][0];
  assign pcoeffCount = cnt_p[L][0];
  assign maxFullness = full_p[L][0];
  assign almostFull  = (maxFullness >= AF_TH);

  logic [TOTAL_WIDTH-1:0] total_q;
  logic                   ovf_q;
  logic [TOTAL_WIDTH-1:0] acc_base;
  logic [TOTAL_WIDTH:0]   add_res;

  // A clear coincident with a result restarts the total from that result.
  assign acc_base = clearTotal ? '0 : total_q;
  assign add_res  = sat_add(acc_base, summedData);

  // Running total stage, one cycle behind the output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else if (outValid) begin
      total_q <= add_res[TOTAL_WIDTH-1:0];
      ovf_q   <= !clearTotal && (ovf_q || add_res[TOTAL_WIDTH]);
    end else if (clearTotal) begin
      total_q <= '0;
      ovf_q   <= 1'b0;
    end
  end

  assign totalSum      = total_q;
  assign totalOverflow = ovf_q;

endmodule

// File: tb/tb_pipeline_pack_reduce.sv
// Directed bench for pipeline_pack_reduce: a 4-lane instance with a 40-bit total
// and a 3-lane instance with default widths.
module tb_pipeline_pack_reduce;

  localparam logic [37:0] MAXS = 38'h3F_FFFF_FFFF;
  localparam logic [39:0] SUM4 = 40'hFF_FFFF_FFFC;
  localparam logic [39:0] MAXT = 40'hFF_FFFF_FFFF;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [151:0] sums;
  logic [11:0]  cnts;
  logic [19:0]  fulls;
  logic         in_valid;
  logic [8:0]   in_idx;
  logic         clear_total;
  logic         out_valid;
  logic [8:0]   out_idx;
  logic [39:0]  summed;
  logic [4:0]   pcount;
  logic [4:0]   max_full;
  logic         almost_full;
  logic [39:0]  total;
  logic         total_ovf;

  logic [113:0] sums3;
  logic [8:0]   cnts3;
  logic [14:0]  fulls3;
  logic         in_valid3;
  logic [8:0]   in_idx3;
  logic         clear3;
  logic         out_valid3;
  logic [8:0]   out_idx3;
  logic [39:0]  summed3;
  logic [4:0]   pcount3;
  logic [4:0]   max_full3;
  logic         af3;
  logic [47:0]  total3;
  logic         ovf3;

  pipeline_pack_reduce #(.NUM_LANES(4), .TOTAL_WIDTH(40)) dut (
    .clk(clk), .rst(rst), .laneSums(sums), .laneCounts(cnts), .laneFullness(fulls),
    .inValid(in_valid), .inBotIndex(in_idx), .clearTotal(clear_total),
    .outValid(out_valid), .outBotIndex(out_idx), .summedData(summed), .pcoeffCount(pcount),
    .maxFullness(max_full), .almostFull(almost_full), .totalSum(total), .totalOverflow(total_ovf)
  );

  pipeline_pack_reduce #(.NUM_LANES(3)) dut3 (
    .clk(clk), .rst(rst), .laneSums(sums3), .laneCounts(cnts3), .laneFullness(fulls3),
    .inValid(in_valid3), .inBotIndex(in_idx3), .clearTotal(clear3),
    .outValid(out_valid3), .outBotIndex(out_idx3), .summedData(summed3), .pcoeffCount(pcount3),
    .maxFullness(max_full3), .almostFull(af3), .totalSum(total3), .totalOverflow(ovf3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [37:0] s0, input logic [37:0] s1, input logic [37:0] s2,
                        input logic [37:0] s3, input logic [2:0] c, input logic [8:0] idx,
                        input logic v);
    sums     = {s3, s2, s1, s0};
    cnts     = {4{c}};
    in_idx   = idx;
    in_valid = v;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_total = 1'b0;
    sums  = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    cnts  = 12'($urandom());
    fulls = 20'($urandom());
    in_idx = 9'($urandom());
    in_valid = 1'b1;
    sums3 = '0; cnts3 = '0; fulls3 = '0; in_valid3 = 1'b0; in_idx3 = '0; clear3 = 1'b0;
    repeat (3) tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
    checks++; if (summed !== 40'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", summed); end
    checks++; if (pcount !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pcount); end
    checks++; if (out_idx !== 9'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    checks++; if (max_full !== 5'd0) begin errors++; $display("FAIL reset_maxfull: got %0d want 0", max_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %0d want 0", almost_full); end
    checks++; if (total !== 40'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", total_ovf); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    fulls = '0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_latency;
    set_in(1, 2, 3, 4, 1, 7, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %0d want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0d want 1", out_valid); end
    checks++; if (summed !== 40'd10) begin errors++; $display("FAIL lat_sum: got %0d want 10", summed); end
    checks++; if (pcount !== 5'd4) begin errors++; $display("FAIL lat_count: got %0d want 4", pcount); end
    checks++; if (out_idx !== 9'd7) begin errors++; $display("FAIL lat_idx: got %0d want 7", out_idx); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_drop: got %0d want 0", out_valid); end
    checks++; if (summed !== 40'd10) begin errors++; $display("FAIL lat_sum_hold: got %0d want 10", summed); end
    checks++; if (total !== 40'd10) begin errors++; $display("FAIL lat_total: got %0d want 10", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL lat_ovf: got %0d want 0", total_ovf); end
  endtask

  task automatic test_fullness;
    fulls = {5'd1, 5'd20, 5'd19, 5'd3};
    tick;
    tick;
    checks++; if (max_full !== 5'd20) begin errors++; $display("FAIL full_max20: got %0d want 20", max_full); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af1: got %0d want 1", almost_full); end
    fulls = {5'd1, 5'd2, 5'd19, 5'd3};
    tick;
    checks++; if (max_full !== 5'd20) begin errors++; $display("FAIL full_lat_hold: got %0d want 20", max_full); end
    tick;
    checks++; if (max_full !== 5'd19) begin errors++; $display("FAIL full_max19: got %0d want 19", max_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL full_af0: got %0d want 0", almost_full); end
    fulls = '0;
    tick;
    tick;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_in(MAXS, MAXS, MAXS, MAXS, 7, 9'(100 + i), 1);
      else       set_in(0, 0, 0, 0, 0, 0, 0);
      tick;
      if (i >= 1 && i <= 8) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0d want 1", i - 1, out_valid); end
        checks++; if (summed !== SUM4) begin errors++; $display("FAIL stream_sum[%0d]: got %0d want %0d", i - 1, summed, SUM4); end
        checks++; if (pcount !== 5'd28) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 28", i - 1, pcount); end
        checks++; if (out_idx !== 9'(100 + i - 1)) begin errors++; $display("FAIL stream_idx[%0d]: got %0d want %0d", i - 1, out_idx, 100 + i - 1); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %0d want 0", out_valid); end
  endtask

  task automatic test_saturation;
    clear_total = 1'b1;
    tick;
    clear_total = 1'b0;
    checks++; if (total !== 40'd0) begin errors++; $display("FAIL sat_clear_total: got %0d want 0", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf: got %0d want 0", total_ovf); end
    set_in(MAXS, MAXS, MAXS, MAXS, 7, 20, 1);
    tick;
    set_in(MAXS, MAXS, MAXS, MAXS, 7, 21, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick;
    checks++; if (total !== SUM4) begin errors++; $display("FAIL sat_first_total: got %0d want %0d", total, SUM4); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL sat_first_ovf: got %0d want 0", total_ovf); end
    tick;
    checks++; if (total !== MAXT) begin errors++; $display("FAIL sat_total: got %0d want %0d", total, MAXT); end
    checks++; if (total_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0d want 1", total_ovf); end
    set_in(1, 0, 0, 0, 1, 22, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    checks++; if (total !== MAXT) begin errors++; $display("FAIL sat_hold_total: got %0d want %0d", total, MAXT); end
    checks++; if (total_ovf !== 1'b1) begin errors++; $display("FAIL sat_hold_ovf: got %0d want 1", total_ovf); end
    set_in(5, 0, 0, 0, 1, 23, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick;
    checks++; if (summed !== 40'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL sat_five_out: got %0d/%0d want 5/1", summed, out_valid); end
    clear_total = 1'b1;
    tick;
    clear_total = 1'b0;
    checks++; if (total !== 40'd5) begin errors++; $display("FAIL sat_clr_load_total: got %0d want 5", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL sat_clr_load_ovf: got %0d want 0", total_ovf); end
  endtask

  task automatic test_odd_lanes;
    sums3  = {38'd7, 38'd6, 38'd5};
    cnts3  = {3'd3, 3'd2, 3'd1};
    fulls3 = {5'd4, 5'd9, 5'd2};
    in_idx3 = 9'd9;
    in_valid3 = 1'b1;
    tick;
    in_valid3 = 1'b0;
    sums3 = '0;
    cnts3 = '0;
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL odd_early_valid: got %0d want 0", out_valid3); end
    tick;
    checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL odd_valid: got %0d want 1", out_valid3); end
    checks++; if (summed3 !== 40'd18) begin errors++; $display("FAIL odd_sum: got %0d want 18", summed3); end
    checks++; if (pcount3 !== 5'd6) begin errors++; $display("FAIL odd_count: got %0d want 6", pcount3); end
    checks++; if (out_idx3 !== 9'd9) begin errors++; $display("FAIL odd_idx: got %0d want 9", out_idx3); end
    checks++; if (max_full3 !== 5'd9) begin errors++; $display("FAIL odd_maxfull: got %0d want 9", max_full3); end
    tick;
    checks++; if (total3 !== 48'd18) begin errors++; $display("FAIL odd_total: got %0d want 18", total3); end
    fulls3 = '0;
  endtask

  task automatic test_midstream_reset;
    set_in(1, 1, 1, 1, 1, 11, 1);
    tick;
    set_in(2, 2, 2, 2, 1, 12, 1);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %0d want 0", out_valid); end
    checks++; if (total !== 40'd0) begin errors++; $display("FAIL mid_async_total: got %0d want 0", total); end
    tick;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid[%0d]: got %0d want 0", i, out_valid); end
    end
    checks++; if (total !== 40'd0) begin errors++; $display("FAIL mid_total: got %0d want 0", total); end
    checks++; if (total3 !== 48'd0) begin errors++; $display("FAIL mid_total3: got %0d want 0", total3); end
    set_in(3, 3, 3, 3, 2, 13, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_early: got %0d want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid: got %0d want 1", out_valid); end
    checks++; if (summed !== 40'd12) begin errors++; $display("FAIL mid_post_sum: got %0d want 12", summed); end
    checks++; if (out_idx !== 9'd13) begin errors++; $display("FAIL mid_post_idx: got %0d want 13", out_idx); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_fullness;
    test_back_to_back;
    test_saturation;
    test_odd_lanes;
    test_midstream_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
